ofm_writeback_packer: RTL and testbench

Downstream write-back stage for the PE array output. It captures a full 16-lane OFM vector when every lane reports valid, buffers up to two vectors, and serializes each into four 32-bit words. Those words are written to the next-layer feature RAM at consecutive addresses, with RAM backpressure handled. It ends each layer after a programmed word count and pulses a done flag for the layer sequencer.

---
 rtl/ofm_writeback_packer.sv | 156 +++++++++++++++
 tb/tb_ofm_writeback_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback_packer.sv
// Captures full 16-lane OFM vectors into a 2-deep buffer and writes each one
// to the next-layer feature RAM as four 32-bit words at consecutive addresses.
module ofm_writeback_packer #(
  parameter int NUM_PE = 16,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W-1:0]        num_words,
  input  logic [NUM_PE*DATA_W-1:0] ofm_data,
  input  logic [NUM_PE-1:0]        ofm_valid,
  output logic                     ofm_ack,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [4*DATA_W-1:0]      wr_data,
  input  logic                     wr_ready,
  output logic [1:0]               beat_sel,
  output logic                     busy,
  output logic                     layer_done
);

  localparam int WORD_W = 4 * DATA_W;
  localparam int VEC_W  = NUM_PE * DATA_W;
  localparam int BEATS  = NUM_PE / 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]        beat_sel_q, beat_sel_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              layer_done_q, layer_done_d;
  logic [VEC_W-1:0]  mem_q [2];

  logic              run;
  logic              accept;
  logic              pop;
  logic              last_word;
  logic [VEC_W-1:0]  head_vec;
  logic [WORD_W-1:0] head_words [BEATS];

  assign run       = (state_q == S_RUN);
  assign head_vec  = mem_q[rd_ptr_q];
  assign wr_en     = run && (count_q != 2'd0);
  assign accept    = wr_en && wr_ready;
  assign pop       = accept && (beat_sel_q == 2'd3);
  assign last_word = accept && (word_cnt_q == num_q - ADDR_W'(1));
  assign ofm_ack   = run && (&ofm_valid) && (count_q != 2'd2) && !start;

  // Word g of the head vector holds lanes 4g..4g+3, lowest lane in the low byte.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_words
      assign head_words[gi] = head_vec[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign wr_data    = head_words[beat_sel_q];
  assign wr_addr    = base_q + word_cnt_q;
  assign beat_sel   = beat_sel_q;
  assign busy       = run;
  assign layer_done = layer_done_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    num_d        = num_q;
    word_cnt_d   = word_cnt_q;
    beat_sel_d   = beat_sel_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    layer_done_d = 1'b0;

    if (start) begin
      // A start always flushes; a zero-length layer completes immediately.
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
      beat_sel_d = 2'd0;
      word_cnt_d = '0;
      if (num_words == '0) begin
        state_d      = S_IDLE;
        layer_done_d = 1'b1;
      end else begin
        state_d = S_RUN;
        base_d  = base_addr;
        num_d   = num_words;
      end
    end else if (run) begin
      if (accept) begin
        word_cnt_d = word_cnt_q + ADDR_W'(1);
        beat_sel_d = beat_sel_q + 2'd1;
      end
      if (pop)     rd_ptr_d = ~rd_ptr_q;
      if (ofm_ack) wr_ptr_d = ~wr_ptr_q;
      case ({ofm_ack, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (last_word) begin
        state_d      = S_IDLE;
        layer_done_d = 1'b1;
        wr_ptr_d     = 1'b0;
        rd_ptr_d     = 1'b0;
        count_d      = 2'd0;
        beat_sel_d   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      num_q        <= '0;
      word_cnt_q   <= '0;
      beat_sel_q   <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      num_q        <= num_d;
      word_cnt_q   <= word_cnt_d;
      beat_sel_q   <= beat_sel_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      layer_done_q <= layer_done_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[gi] <= '0;
        end else if (ofm_ack && (wr_ptr_q == 1'(gi))) begin
          mem_q[gi] <= ofm_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ofm_writeback_packer.sv
// Directed and randomized checks of ofm_writeback_packer against a queue-based
// model of the buffered vectors and the layer word counter.
module tb_ofm_writeback_packer;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [31:0]   base_addr;
  logic [31:0]   num_words;
  logic [127:0]  ofm_data;
  logic [15:0]   ofm_valid;
  logic          ofm_ack;
  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic [1:0]    beat_sel;
  logic          busy;
  logic          layer_done;

  ofm_writeback_packer #(.NUM_PE(16), .DATA_W(8), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .ofm_data(ofm_data), .ofm_valid(ofm_valid),
    .ofm_ack(ofm_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .beat_sel(beat_sel), .busy(busy), .layer_done(layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Upstream producer: vectors waiting to be offered, optional valid override.
  logic [127:0] prod_q[$];
  logic         ovr_en;
  logic [15:0]  ovr_val;

  // Reference model: buffered vectors, current beat and layer bookkeeping.
  logic [127:0] m_q[$];
  int           m_beat;
  logic         m_run;
  logic         m_done;
  logic [31:0]  m_cnt;
  logic [31:0]  m_base;
  logic [31:0]  m_num;

  int acc_seen;
  int done_seen;
  int ack_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_beat = 0;
    m_run  = 1'b0;
    m_done = 1'b0;
    m_cnt  = 32'd0;
    m_base = 32'd0;
    m_num  = 32'd0;
  endtask

  // One clock cycle: entered and left 1 time unit after a rising edge.
  task automatic tick();
    logic         e_we;
    logic         e_ack;
    logic         acc;
    logic         last;
    logic [127:0] head;
    if (prod_q.size() > 0) ofm_data = prod_q[0];
    else                   ofm_data = rand_vec();
    if (ovr_en) ofm_valid = ovr_val;
    else        ofm_valid = (prod_q.size() > 0) ? 16'hFFFF : 16'h0000;
    #1;
    e_we  = m_run && (m_q.size() > 0);
    e_ack = m_run && (ofm_valid == 16'hFFFF) && (m_q.size() < 2) && !start;
    chk("ofm_ack", {31'd0, ofm_ack}, {31'd0, e_ack});
    chk("wr_en", {31'd0, wr_en}, {31'd0, e_we});
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("layer_done", {31'd0, layer_done}, {31'd0, m_done});
    if (e_we) begin
      head = m_q[0];
      chk("wr_addr", wr_addr, m_base + m_cnt);
      chk("wr_data", wr_data, head[m_beat*32 +: 32]);
      chk("beat_sel", {30'd0, beat_sel}, m_beat);
    end
    if (wr_en && wr_ready) acc_seen++;
    if (layer_done) done_seen++;
    if (ofm_ack) ack_seen++;
    $display("t=%0t start=%0b vld=%04h ack=%0b we=%0b rdy=%0b addr=%08h data=%08h beat=%0d busy=%0b done=%0b",
             $time, start, ofm_valid, ofm_ack, wr_en, wr_ready, wr_addr, wr_data, beat_sel, busy, layer_done);

    m_done = 1'b0;
    if (start) begin
      m_q.delete();
      m_beat = 0;
      m_cnt  = 32'd0;
      if (num_words == 32'd0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else begin
        m_run  = 1'b1;
        m_base = base_addr;
        m_num  = num_words;
      end
    end else if (m_run) begin
      acc  = e_we && wr_ready;
      last = acc && (m_cnt == m_num - 32'd1);
      if (e_ack) m_q.push_back(ofm_data);
      if (acc) begin
        m_cnt++;
        m_beat++;
        if (m_beat == 4) begin
          m_beat = 0;
          void'(m_q.pop_front());
        end
      end
      if (last) begin
        m_q.delete();
        m_beat = 0;
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    if (e_ack && !ovr_en && prod_q.size() > 0) void'(prod_q.pop_front());
    start = 1'b0;
  endtask

  task automatic begin_layer(input logic [31:0] ba, input logic [31:0] nw);
    base_addr = ba;
    num_words = nw;
    start     = 1'b1;
  endtask

  task automatic clear_counts();
    acc_seen  = 0;
    done_seen = 0;
    ack_seen  = 0;
  endtask

  logic [127:0] lane_vec;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
    wr_ready = 1'b0; ofm_data = '0; ofm_valid = '0;
    ovr_en = 1'b0; ovr_val = 16'h0;
    model_reset();
    clear_counts();
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_beat_sel", {30'd0, beat_sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_layer_done", {31'd0, layer_done}, 32'd0);
    chk("rst_ofm_ack", {31'd0, ofm_ack}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) lane_vec[i*8 +: 8] = 8'(8'h10 + i);

    // Single vector, basic order.
    clear_counts();
    prod_q.push_back(lane_vec);
    wr_ready = 1'b1;
    begin_layer(32'h100, 32'd4);
    repeat (9) tick();
    chk("basic_writes", acc_seen, 32'd4);
    chk("basic_done", done_seen, 32'd1);

    // Backpressure with wr_ready 1,0,0,1,0,0,...
    clear_counts();
    prod_q.delete();
    prod_q.push_back(lane_vec);
    begin_layer(32'h100, 32'd4);
    for (int i = 0; i < 18; i++) begin
      wr_ready = (i % 3 == 0);
      tick();
    end
    chk("bp_writes", acc_seen, 32'd4);
    chk("bp_done", done_seen, 32'd1);

    // FIFO full stall: three vectors offered while the RAM refuses.
    clear_counts();
    prod_q.delete();
    for (int i = 0; i < 3; i++) prod_q.push_back(rand_vec());
    wr_ready = 1'b0;
    begin_layer(32'h4000, 32'd16);
    repeat (7) tick();
    chk("full_acks_stalled", ack_seen, 32'd2);
    wr_ready = 1'b1;
    repeat (16) tick();
    chk("full_writes", acc_seen, 32'd12);
    chk("full_acks", ack_seen, 32'd3);

    // Partial valid is ignored, then a full vector is captured.
    clear_counts();
    prod_q.delete();
    prod_q.push_back(rand_vec());
    ovr_en = 1'b1;
    ovr_val = 16'h7FFF;
    begin_layer(32'h20, 32'd4);
    repeat (11) tick();
    chk("partial_acks", ack_seen, 32'd0);
    chk("partial_writes", acc_seen, 32'd0);
    ovr_en = 1'b0;
    repeat (8) tick();
    chk("partial_then_full_acks", ack_seen, 32'd1);
    chk("partial_then_full_writes", acc_seen, 32'd4);

    // Early end with address wrap.
    clear_counts();
    prod_q.delete();
    prod_q.push_back(rand_vec());
    begin_layer(32'hFFFF_FFFE, 32'd3);
    repeat (9) tick();
    chk("wrap_writes", acc_seen, 32'd3);
    chk("wrap_done", done_seen, 32'd1);
    chk("wrap_idle_we", {31'd0, wr_en}, 32'd0);

    // Restart mid-drain with a zero-length layer.
    prod_q.delete();
    prod_q.push_back(rand_vec());
    prod_q.push_back(rand_vec());
    begin_layer(32'h200, 32'd8);
    repeat (4) tick();
    clear_counts();
    begin_layer(32'h300, 32'd0);
    tick();
    acc_seen = 0;
    repeat (6) tick();
    chk("restart_writes", acc_seen, 32'd0);
    chk("restart_done", done_seen, 32'd1);

    // Asynchronous reset in the middle of a write burst.
    prod_q.delete();
    prod_q.push_back(rand_vec());
    prod_q.push_back(rand_vec());
    begin_layer(32'h500, 32'd8);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("arst_wr_addr", wr_addr, 32'd0);
    chk("arst_wr_data", wr_data, 32'd0);
    chk("arst_beat_sel", {30'd0, beat_sel}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ofm_ack", {31'd0, ofm_ack}, 32'd0);
    chk("arst_layer_done", {31'd0, layer_done}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("arst_hold_wr_en", {31'd0, wr_en}, 32'd0);
    end
    rst_n = 1'b1;
    model_reset();
    prod_q.delete();
    @(posedge clk);
    #1;

    // Randomized layers with random backpressure, restarts and vector supply.
    for (int l = 0; l < 8; l++) begin
      prod_q.delete();
      for (int v = 0; v < int'($urandom_range(1, 6)); v++) prod_q.push_back(rand_vec());
      wr_ready = $urandom_range(0, 1);
      begin_layer($urandom, $urandom_range(1, 24));
      tick();
      for (int c = 0; c < 60; c++) begin
        wr_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) prod_q.push_back(rand_vec());
        if ($urandom_range(0, 49) == 0) begin_layer($urandom, $urandom_range(0, 12));
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
